vga_rx_monitor: RTL and testbench
=================================

# vga_rx_monitor

Receiving end of the VGA pixel interface: samples HS, VS and 4-bit R/G/B on the pixel clock, recovers horizontal/vertical position from sync edges, and qualifies the stream against 640x480 timing (800 x 521 clocks per frame). Emits per-pixel coordinates and colour, a per-frame 16-bit colour checksum and timing-error reporting. Used on-chip as a loopback checker of the VGA output and as the bench-side monitor.

## Interface
- H_SYNC, 96, HS low width in clocks
- H_BACK, 48, horizontal back porch
- H_DISP, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, VS low width in lines
- V_BACK, 29, vertical back porch
- V_DISP, 480, active lines
- V_FRONT, 10, vertical front porch
- CLK  in  1  pixel clock
- RST  in  1  reset; asynchronous, active-low
- HS, VS  in  1 each  sync inputs, active-low
- R, G, B  in  4 each  colour inputs, same-cycle aligned with HS/VS
- clr  in  1  synchronous clear of err_cnt
- locked  out  1  timing lock indicator
- px_valid  out  1  active-area pixel strobe (LOCKED only)
- px_x  out  10  column 0..639
- px_y  out  9  row 0..479
- px_rgb  out  12  {R,G,B}
- frame_done  out  1  one-cycle pulse, frame_sum updated
- frame_sum  out  16  checksum of last complete locked frame
- err_hline  out  1  one-cycle pulse on line-timing error
- err_vframe  out  1  one-cycle pulse on frame-timing error
- err_cnt  out  8  saturating error count

## Operation
- Input stage registers HS, VS, RGB once; falling edges detected on the registered copy (current 0, previous 1). Falling HS = position h=0; falling VS (coincident with an HS fall) = v=0.
- h: 11-bit, increments each clock, reset to 0 on HS fall. v: 10-bit, increments on each HS fall, reset to 0 on VS fall.
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (521).
- Line check: on HS fall, previous h must equal H_TOTAL-1, else err_hline. h reaching 2047 without HS fall is also err_hline (h saturates).
- Frame check: on VS fall, previous v must equal V_TOTAL-1, else err_vframe. v reaching 1023 is err_vframe.
- Active: h in [H_SYNC+H_BACK, H_TOTAL-H_FRONT), v in [V_SYNC+V_BACK, V_TOTAL-V_FRONT); px_x = h-144, px_y = v-31 (default params).
- FSM: HUNT -> SYNC on first VS fall. SYNC -> LOCKED on next VS fall if no error since entry; any error in SYNC -> HUNT. LOCKED -> HUNT on any error. Error on the same edge as a VS fall takes priority over the transition.
- Checksum: 16-bit accumulator, modulo 2^16 sum of zero-extended px_rgb over active pixels. Cleared on every VS fall. On a VS fall in LOCKED where the whole preceding frame was in LOCKED and error-free, frame_sum <= accumulator and frame_done pulses.
- err_cnt: +1 per cycle with err_hline or err_vframe, saturates at 255; clr zeroes it (clr wins over a simultaneous increment).

## Timing
- Reset values: locked 0, px_valid 0, px_x 0, px_y 0, px_rgb 0, frame_done 0, frame_sum 0, err_hline 0, err_vframe 0, err_cnt 0; FSM HUNT; h, v 0.
- Latency: pins -> px_* registered outputs = 2 clocks. Error pulses and frame_done appear 2 clocks after the triggering sync edge at pins.
- locked = (state == LOCKED), registered.
- Reset asserted mid-frame: all state cleared immediately; reacquisition requires HUNT -> SYNC -> LOCKED again (minimum one full frame after first VS fall).
- First frame_done after reset: third VS fall.

## Structure
- Shared package vga_timing_pkg: the eight timing constants, H_TOTAL/V_TOTAL, FSM state enum (HUNT, SYNC, LOCKED); the VGA output block uses the same constants.
- One sub-module: vga_sync_edge (input register plus falling-edge detect for HS/VS).

## Test plan
- Reset then 3 frames of constant RGB 0xFFF at nominal timing -> locked after 2nd VS fall, frame_done at 3rd, frame_sum = 0x5000, err_cnt 0.
- Ramp pattern px_rgb = x mod 4096 -> px_x/px_y match 0..639/0..479, px_valid count 307200 per frame.
- One line of 801 clocks while locked -> err_hline pulse, locked drops, err_cnt = 1, relock after 2 clean VS falls.
- Frame of 520 lines -> err_vframe, no frame_done for that frame, frame_sum unchanged.
- HS held high 2100 clocks -> err_hline at h saturation, state HUNT.
- 300 forced errors then clr -> err_cnt saturates at 255, returns 0 the cycle after clr.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480 timing constants and receive-monitor state encoding, shared
// by the VGA output block and the receive monitor.
package vga_timing_pkg;

   localparam int H_SYNC  = 96;
   localparam int H_BACK  = 48;
   localparam int H_DISP  = 640;
   localparam int H_FRONT = 16;
   localparam int V_SYNC  = 2;
   localparam int V_BACK  = 29;
   localparam int V_DISP  = 480;
   localparam int V_FRONT = 10;

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } mon_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Input register for HS/VS/RGB plus falling-edge detection on the registered
// sync copies. Syncs reset high (idle) so reset release never looks like an edge.
module vga_sync_edge (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        hs_i,
   input  logic        vs_i,
   input  logic [3:0]  r_i,
   input  logic [3:0]  g_i,
   input  logic [3:0]  b_i,
   output logic        hs_fall_o,
   output logic        vs_fall_o,
   output logic [11:0] rgb_o
);

   logic        hs_q, hs_prev_q, vs_q, vs_prev_q;
   logic [11:0] rgb_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hs_q      <= 1'b1;
         hs_prev_q <= 1'b1;
         vs_q      <= 1'b1;
         vs_prev_q <= 1'b1;
         rgb_q     <= '0;
      end else begin
         hs_q      <= hs_i;
         hs_prev_q <= hs_q;
         vs_q      <= vs_i;
         vs_prev_q <= vs_q;
         rgb_q     <= {r_i, g_i, b_i};
      end
   end

   assign hs_fall_o = hs_prev_q & ~hs_q;
   assign vs_fall_o = vs_prev_q & ~vs_q;
   assign rgb_o     = rgb_q;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers h/v position from sync edges, qualifies line and
// frame timing, emits active pixels with coordinates and a per-frame checksum.
module vga_rx_monitor
   import vga_timing_pkg::*;
#(
   parameter int P_H_SYNC  = H_SYNC,
   parameter int P_H_BACK  = H_BACK,
   parameter int P_H_DISP  = H_DISP,
   parameter int P_H_FRONT = H_FRONT,
   parameter int P_V_SYNC  = V_SYNC,
   parameter int P_V_BACK  = V_BACK,
   parameter int P_V_DISP  = V_DISP,
   parameter int P_V_FRONT = V_FRONT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        hs_i,
   input  logic        vs_i,
   input  logic [3:0]  r_i,
   input  logic [3:0]  g_i,
   input  logic [3:0]  b_i,
   input  logic        clr_i,
   output logic        locked_o,
   output logic        px_valid_o,
   output logic [9:0]  px_x_o,
   output logic [8:0]  px_y_o,
   output logic [11:0] px_rgb_o,
   output logic        frame_done_o,
   output logic [15:0] frame_sum_o,
   output logic        err_hline_o,
   output logic        err_vframe_o,
   output logic [7:0]  err_cnt_o,
   output mon_state_e  state_o
);

   localparam int H_TOT   = P_H_SYNC + P_H_BACK + P_H_DISP + P_H_FRONT;
   localparam int V_TOT   = P_V_SYNC + P_V_BACK + P_V_DISP + P_V_FRONT;
   localparam int H_ACT_S = P_H_SYNC + P_H_BACK;
   localparam int H_ACT_E = H_TOT - P_H_FRONT;
   localparam int V_ACT_S = P_V_SYNC + P_V_BACK;
   localparam int V_ACT_E = V_TOT - P_V_FRONT;

   logic        hs_fall, vs_fall;
   logic [11:0] rgb;

   vga_sync_edge u_sync_edge (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .hs_i      (hs_i),
      .vs_i      (vs_i),
      .r_i       (r_i),
      .g_i       (g_i),
      .b_i       (b_i),
      .hs_fall_o (hs_fall),
      .vs_fall_o (vs_fall),
      .rgb_o     (rgb)
   );

   mon_state_e  state_q, state_d;
   logic [10:0] h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic [15:0] acc_q, acc_d, sum_q, sum_d;
   logic [9:0]  px_x_q, px_x_d;
   logic [8:0]  px_y_q, px_y_d;
   logic [11:0] px_rgb_q, px_rgb_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        frame_ok_q, frame_ok_d;
   logic        locked_q, px_valid_q, px_valid_d, frame_done_q, frame_done_d;
   logic        err_h_q, err_v_q, err_h, err_v, err, active;

   // h_q/v_q hold the position of the previous sample; h_d/v_d that of the sample now in rgb.
   always_comb begin
      h_d          = h_q;
      v_d          = v_q;
      err_h        = 1'b0;
      err_v        = 1'b0;
      state_d      = state_q;
      frame_ok_d   = frame_ok_q;
      frame_done_d = 1'b0;
      acc_d        = acc_q;
      sum_d        = sum_q;
      px_valid_d   = 1'b0;
      px_x_d       = px_x_q;
      px_y_d       = px_y_q;
      px_rgb_d     = px_rgb_q;
      err_cnt_d    = err_cnt_q;

      if (hs_fall)                h_d = '0;
      else if (h_q != 11'h7FF)    h_d = h_q + 11'd1;
      if (vs_fall)                           v_d = '0;
      else if (hs_fall && v_q != 10'h3FF)    v_d = v_q + 10'd1;

      // No timing reference exists until the first VS fall, so HUNT never reports errors.
      if (state_q != HUNT) begin
         err_h = (hs_fall && h_q != 11'(H_TOT - 1)) || (!hs_fall && h_q == 11'h7FE);
         err_v = (vs_fall && v_q != 10'(V_TOT - 1)) ||
                 (hs_fall && !vs_fall && v_q == 10'h3FE);
      end
      err = err_h | err_v;

      active = (h_d >= 11'(H_ACT_S)) && (h_d < 11'(H_ACT_E)) &&
               (v_d >= 10'(V_ACT_S)) && (v_d < 10'(V_ACT_E));

      case (state_q)
         HUNT:    if (vs_fall) state_d = SYNC;
         SYNC:    if (err) state_d = HUNT; else if (vs_fall) state_d = LOCKED;
         LOCKED:  if (err) state_d = HUNT;
         default: state_d = HUNT;
      endcase

      // frame_ok_q: the frame in progress started in LOCKED and has seen no error.
      frame_done_d = vs_fall && (state_q == LOCKED) && !err && frame_ok_q;
      if (vs_fall) frame_ok_d = (state_d == LOCKED);
      else         frame_ok_d = frame_ok_q & ~err;
      if (frame_done_d) sum_d = acc_q;

      if (vs_fall)     acc_d = '0;
      else if (active) acc_d = acc_q + {4'b0, rgb};

      px_valid_d = active && (state_q == LOCKED);
      if (px_valid_d) begin
         px_x_d   = 10'(h_d - 11'(H_ACT_S));
         px_y_d   = 9'(v_d - 10'(V_ACT_S));
         px_rgb_d = rgb;
      end

      if (clr_i)                          err_cnt_d = '0;
      else if (err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= HUNT;
         h_q          <= '0;
         v_q          <= '0;
         acc_q        <= '0;
         sum_q        <= '0;
         frame_ok_q   <= 1'b0;
         frame_done_q <= 1'b0;
         px_valid_q   <= 1'b0;
         px_x_q       <= '0;
         px_y_q       <= '0;
         px_rgb_q     <= '0;
         err_h_q      <= 1'b0;
         err_v_q      <= 1'b0;
         err_cnt_q    <= '0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         v_q          <= v_d;
         acc_q        <= acc_d;
         sum_q        <= sum_d;
         frame_ok_q   <= frame_ok_d;
         frame_done_q <= frame_done_d;
         px_valid_q   <= px_valid_d;
         px_x_q       <= px_x_d;
         px_y_q       <= px_y_d;
         px_rgb_q     <= px_rgb_d;
         err_h_q      <= err_h;
         err_v_q      <= err_v;
         err_cnt_q    <= err_cnt_d;
         locked_q     <= (state_d == LOCKED);
      end
   end

   assign locked_o     = locked_q;
   assign px_valid_o   = px_valid_q;
   assign px_x_o       = px_x_q;
   assign px_y_o       = px_y_q;
   assign px_rgb_o     = px_rgb_q;
   assign frame_done_o = frame_done_q;
   assign frame_sum_o  = sum_q;
   assign err_hline_o  = err_h_q;
   assign err_vframe_o = err_v_q;
   assign err_cnt_o    = err_cnt_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down raster (17 x 11 clocks,
// 8 x 5 active) so whole frames take a couple of hundred clocks each.
module tb_vga_rx_monitor;
   import vga_timing_pkg::*;

   localparam int HSW = 4, HBP = 3, HDP = 8, HFP = 2;
   localparam int VSW = 2, VBP = 2, VDP = 5, VFP = 2;
   localparam int HT  = HSW + HBP + HDP + HFP;   // 17
   localparam int VT  = VSW + VBP + VDP + VFP;   // 11
   localparam int HAS = HSW + HBP, HAE = HT - HFP;
   localparam int VAS = VSW + VBP, VAE = VT - VFP;

   logic        clk, rst_n, hs, vs, clr;
   logic [3:0]  r, g, b;
   logic        locked, px_valid, frame_done, err_hline, err_vframe;
   logic [9:0]  px_x;
   logic [8:0]  px_y;
   logic [11:0] px_rgb;
   logic [15:0] frame_sum;
   logic [7:0]  err_cnt;
   mon_state_e  state;

   vga_rx_monitor #(
      .P_H_SYNC(HSW), .P_H_BACK(HBP), .P_H_DISP(HDP), .P_H_FRONT(HFP),
      .P_V_SYNC(VSW), .P_V_BACK(VBP), .P_V_DISP(VDP), .P_V_FRONT(VFP)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .hs_i(hs), .vs_i(vs),
      .r_i(r), .g_i(g), .b_i(b), .clr_i(clr),
      .locked_o(locked), .px_valid_o(px_valid), .px_x_o(px_x), .px_y_o(px_y),
      .px_rgb_o(px_rgb), .frame_done_o(frame_done), .frame_sum_o(frame_sum),
      .err_hline_o(err_hline), .err_vframe_o(err_vframe), .err_cnt_o(err_cnt),
      .state_o(state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int n_fd = 0, n_eh = 0, n_ev = 0, n_px = 0;
   logic [30:0] exp_q[$];   // {y, x, rgb} of pixels expected on px_*

   typedef struct {
      int          mode;      // 0: constant 0xFFF, 1: ramp x + 16*y
      int          nlines;
      int          bad_line;  // line driven one clock long, -1 for none
      int          exp_fd, exp_eh, exp_ev;
      logic        exp_locked;
      int          exp_px;
      logic [7:0]  exp_cnt;
      logic [15:0] exp_sum;
   } row_t;
   row_t rows[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard / pulse counters, run once per clock just after the edge
   task automatic sample();
      logic [30:0] e;
      if (err_hline)  n_eh++;
      if (err_vframe) n_ev++;
      if (frame_done) n_fd++;
      if (px_valid) begin
         n_px++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL px_unexpected: got x=%0d y=%0d rgb=0x%0h, expected no pixel",
                     px_x, px_y, px_rgb);
         end else begin
            e = exp_q.pop_front();
            check("px", {1'b0, px_y, px_x, px_rgb}, {1'b0, e});
         end
      end
   endtask

   // driver tasks
   task automatic drive_cycle(input logic h, input logic v, input logic [11:0] rgb);
      hs = h;
      vs = v;
      {r, g, b} = rgb;
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic drive_line(input int len, input int l, input int mode, input bit push);
      for (int c = 0; c < len; c++) begin
         logic        act;
         logic [11:0] px;
         act = (c >= HAS) && (c < HAE) && (l >= VAS) && (l < VAE);
         if (act) px = (mode == 0) ? 12'hFFF : 12'((c - HAS) + 16 * (l - VAS));
         else     px = 12'($urandom_range(0, 4095));
         if (act && push) exp_q.push_back({9'(l - VAS), 10'(c - HAS), px});
         drive_cycle((c < HSW) ? 1'b0 : 1'b1, (l < VSW) ? 1'b0 : 1'b1, px);
      end
   endtask

   task automatic drive_frame(input int nlines, input int bad_line, input int mode, input bit push);
      for (int l = 0; l < nlines; l++)
         drive_line((l == bad_line) ? HT + 1 : HT, l, mode, push);
   endtask

   task automatic check_queue_empty(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int fd0, eh0, ev0, px0, hit;
      // Frame sums over the 40 active pixels: 40*0xFFF mod 2^16 = 0x7FD8,
      // ramp sum(x) + 16*8*sum(y) = 140 + 1280 = 0x058C.
      rows[0] = '{0, 11, -1, 0, 0, 0, 1'b0,  0, 8'd0, 16'h0000};
      rows[1] = '{0, 11, -1, 0, 0, 0, 1'b1, 40, 8'd0, 16'h0000};
      rows[2] = '{0, 11, -1, 1, 0, 0, 1'b1, 40, 8'd0, 16'h7FD8};
      rows[3] = '{1, 11, -1, 1, 0, 0, 1'b1, 40, 8'd0, 16'h7FD8};
      rows[4] = '{1, 11,  3, 1, 1, 0, 1'b0,  0, 8'd1, 16'h058C};
      rows[5] = '{1, 11, -1, 0, 0, 0, 1'b0,  0, 8'd1, 16'h058C};
      rows[6] = '{0, 11, -1, 0, 0, 0, 1'b1, 40, 8'd1, 16'h058C};
      rows[7] = '{1, 10, -1, 1, 0, 0, 1'b1, 40, 8'd1, 16'h7FD8};
      rows[8] = '{1, 11, -1, 0, 0, 1, 1'b0,  0, 8'd2, 16'h7FD8};

      rst_n = 1'b0; hs = 1'b1; vs = 1'b1; {r, g, b} = '0; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_locked", locked, 0);
      check("rst_px_valid", px_valid, 0);
      check("rst_px_x", px_x, 0);
      check("rst_px_y", px_y, 0);
      check("rst_px_rgb", px_rgb, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_sum", frame_sum, 0);
      check("rst_err_hline", err_hline, 0);
      check("rst_err_vframe", err_vframe, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_state", state, HUNT);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         fd0 = n_fd; eh0 = n_eh; ev0 = n_ev; px0 = n_px;
         drive_frame(rows[i].nlines, rows[i].bad_line, rows[i].mode, rows[i].exp_px != 0);
         check($sformatf("row%0d_frame_done", i), n_fd - fd0, rows[i].exp_fd);
         check($sformatf("row%0d_err_hline", i), n_eh - eh0, rows[i].exp_eh);
         check($sformatf("row%0d_err_vframe", i), n_ev - ev0, rows[i].exp_ev);
         check($sformatf("row%0d_locked", i), locked, rows[i].exp_locked);
         check($sformatf("row%0d_px_count", i), n_px - px0, rows[i].exp_px);
         check($sformatf("row%0d_err_cnt", i), err_cnt, rows[i].exp_cnt);
         check($sformatf("row%0d_frame_sum", i), frame_sum, rows[i].exp_sum);
         check_queue_empty($sformatf("row%0d_px_missing", i));
      end

      // HS stuck high while locked: h saturates, one err_hline, back to HUNT.
      drive_frame(VT, -1, 0, 1'b0);
      drive_frame(VT, -1, 0, 1'b1);
      check("sat_pre_locked", locked, 1);
      drive_line(HT, 0, 0, 1'b0);
      eh0 = n_eh;
      hit = -1;
      for (int i = 0; i < 2100; i++) begin
         drive_cycle(1'b1, 1'b1, 12'h000);
         if (err_hline && hit < 0) hit = i;
      end
      check("sat_err_hline_count", n_eh - eh0, 1);
      // last line position was HT-1; hold sample i sits at HT+i, h=2047 at i=2047-HT,
      // and the pulse is visible one clock later.
      check("sat_err_hline_time", hit, 2047 - HT + 1);
      check("sat_state", state, HUNT);
      check("sat_locked", locked, 0);
      check("sat_err_cnt", err_cnt, 3);
      check_queue_empty("sat_px_missing");

      // Forced short lines while in SYNC: one err_hline per 4-clock burst.
      eh0 = n_eh;
      for (int i = 0; i < 300; i++) begin
         drive_cycle(1'b0, 1'b0, 12'h000);
         drive_cycle(1'b1, 1'b1, 12'h000);
         drive_cycle(1'b0, 1'b1, 12'h000);
         if (i == 0) check("err_latency_1clk", err_hline, 0);
         drive_cycle(1'b1, 1'b1, 12'h000);
         if (i == 0) check("err_latency_2clk", err_hline, 1);
      end
      check("forced_err_count", n_eh - eh0, 300);
      check("err_cnt_saturated", err_cnt, 255);
      drive_cycle(1'b0, 1'b0, 12'h000);
      drive_cycle(1'b1, 1'b1, 12'h000);
      drive_cycle(1'b0, 1'b1, 12'h000);
      clr = 1'b1;
      drive_cycle(1'b1, 1'b1, 12'h000);
      check("clr_with_err_pulse", err_hline, 1);
      check("clr_wins_err_cnt", err_cnt, 0);
      clr = 1'b0;
      drive_cycle(1'b1, 1'b1, 12'h000);
      check("clr_err_cnt_hold", err_cnt, 0);

      // Relock, then reset mid-frame: everything clears, reacquisition starts over.
      fd0 = n_fd;
      drive_frame(VT, -1, 0, 1'b0);
      drive_frame(VT, -1, 0, 1'b1);
      drive_frame(VT, -1, 0, 1'b1);
      check("relock_frame_done", n_fd - fd0, 1);
      check("relock_locked", locked, 1);
      check("relock_frame_sum", frame_sum, 16'h7FD8);
      drive_frame(6, -1, 1, 1'b1);
      check_queue_empty("mid_px_missing");
      hs = 1'b1; vs = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_locked", locked, 0);
      check("mid_rst_state", state, HUNT);
      check("mid_rst_frame_sum", frame_sum, 0);
      check("mid_rst_px_x", px_x, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      fd0 = n_fd;
      drive_frame(VT, -1, 0, 1'b0);
      check("post_rst_vs1_locked", locked, 0);
      drive_frame(VT, -1, 1, 1'b1);
      check("post_rst_vs2_locked", locked, 1);
      check("post_rst_no_frame_done", n_fd - fd0, 0);
      drive_line(HT, 0, 1, 1'b0);
      drive_cycle(1'b1, 1'b1, 12'h000);
      check("post_rst_vs3_frame_done", n_fd - fd0, 1);
      check("post_rst_vs3_frame_sum", frame_sum, 16'h058C);
      check_queue_empty("post_rst_px_missing");

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
